// File: rtl/issue_scoreboard.sv
// In-order issue stage: a 32-entry busy scoreboard gates decode on RAW/WAW hazards
// and feeds a one-entry valid/ready output register toward execute.
module issue_scoreboard #(
    parameter int NREGS     = 32,
    parameter int RIDX_W    = 5,
    parameter int PAYLOAD_W = 32,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [RIDX_W-1:0]    in_rs,
    input  logic [RIDX_W-1:0]    in_rt,
    input  logic [RIDX_W-1:0]    in_rd,
    input  logic                 in_uses_rs,
    input  logic                 in_uses_rt,
    input  logic                 in_writes_rd,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RIDX_W-1:0]    out_rs,
    output logic [RIDX_W-1:0]    out_rt,
    output logic [RIDX_W-1:0]    out_rd,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_writes_rd,
    input  logic                 wb_valid,
    input  logic [RIDX_W-1:0]    wb_rd,
    input  logic                 flush,
    output logic [NREGS-1:0]     busy_vec,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef enum logic {
        EMPTY,
        FULL
    } out_state_e;

    out_state_e state_q, state_d;

    logic [NREGS-1:0]     busy_q, busy_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [RIDX_W-1:0]    out_rs_q, out_rs_d;
    logic [RIDX_W-1:0]    out_rt_q, out_rt_d;
    logic [RIDX_W-1:0]    out_rd_q, out_rd_d;
    logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
    logic                 out_writes_rd_q, out_writes_rd_d;

    logic [NREGS-1:0] wb_hit;
    logic [NREGS-1:0] eff_busy;
    logic             hazard;
    logic             fire;

    // A writeback landing this cycle is bypassed so its consumer issues with no bubble.
    always_comb begin
        wb_hit = '0;
        for (int i = 0; i < NREGS; i++) begin
            wb_hit[i] = wb_valid && (wb_rd == RIDX_W'(i));
        end
        eff_busy = busy_q & ~wb_hit;
        hazard   = (in_uses_rs   && eff_busy[in_rs]) ||
                   (in_uses_rt   && eff_busy[in_rt]) ||
                   (in_writes_rd && eff_busy[in_rd]);
        in_ready = !hazard && ((state_q == EMPTY) || out_ready) && !flush;
        fire     = in_valid && in_ready;
    end

    // Set is applied after the writeback clear so a new producer wins; flush overrides both.
    always_comb begin
        busy_d = busy_q & ~wb_hit;
        if (fire && in_writes_rd && (in_rd != '0)) begin
            busy_d[in_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (fire) state_d = FULL;
            FULL:  if (out_ready && !fire) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        out_rs_d        = out_rs_q;
        out_rt_d        = out_rt_q;
        out_rd_d        = out_rd_q;
        out_payload_d   = out_payload_q;
        out_writes_rd_d = out_writes_rd_q;
        if (fire) begin
            out_rs_d        = in_rs;
            out_rt_d        = in_rt;
            out_rd_d        = in_rd;
            out_payload_d   = in_payload;
            out_writes_rd_d = in_writes_rd;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= EMPTY;
            busy_q          <= '0;
            stall_cnt_q     <= '0;
            out_rs_q        <= '0;
            out_rt_q        <= '0;
            out_rd_q        <= '0;
            out_payload_q   <= '0;
            out_writes_rd_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            stall_cnt_q     <= stall_cnt_d;
            out_rs_q        <= out_rs_d;
            out_rt_q        <= out_rt_d;
            out_rd_q        <= out_rd_d;
            out_payload_q   <= out_payload_d;
            out_writes_rd_q <= out_writes_rd_d;
        end
    end

    assign out_valid     = (state_q == FULL);
    assign out_rs        = out_rs_q;
    assign out_rt        = out_rt_q;
    assign out_rd        = out_rd_q;
    assign out_payload   = out_payload_q;
    assign out_writes_rd = out_writes_rd_q;
    assign busy_vec      = busy_q;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: hazards, writeback bypass, back-pressure,
// register 0, flush and reset, each checked against hand-computed values.
module tb_issue_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic        in_uses_rs, in_uses_rt, in_writes_rd;
    logic [31:0] in_payload;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic [31:0] out_payload;
    logic        out_writes_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy_vec;
    logic [15:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    issue_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_rd        (in_rd),
        .in_uses_rs   (in_uses_rs),
        .in_uses_rt   (in_uses_rt),
        .in_writes_rd (in_writes_rd),
        .in_payload   (in_payload),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rs       (out_rs),
        .out_rt       (out_rt),
        .out_rd       (out_rd),
        .out_payload  (out_payload),
        .out_writes_rd(out_writes_rd),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .busy_vec     (busy_vec),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic urs, input logic urt,
                                 input logic wrd, input logic [31:0] pl);
        in_valid     = v;
        in_rs        = rs;
        in_rt        = rt;
        in_rd        = rd;
        in_uses_rs   = urs;
        in_uses_rt   = urt;
        in_writes_rd = wrd;
        in_payload   = pl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleIn();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic writeBack(input logic [4:0] rd);
        wb_valid = 1'b1;
        wb_rd    = rd;
        tick();
        wb_valid = 1'b0;
        wb_rd    = 5'd0;
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        wb_valid  = 1'b0;
        wb_rd     = 5'd0;
        flush     = 1'b0;
        idleIn();
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy_vec), 64'd0);
        checkOutput("rst_stall", 64'(stall_cnt), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_payload", 64'(out_payload), 64'd0);
        checkOutput("rst_rd", 64'(out_rd), 64'd0);

        // Independent stream writing r1..r4
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 5'd0, 5'd0, 5'(k), 1'b0, 1'b0, 1'b1, 32'h100 + 32'(k));
            #1;
            checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
            tick();
            checkOutput("stream_out_valid", 64'(out_valid), 64'd1);
            checkOutput("stream_out_rd", 64'(out_rd), 64'(k));
            checkOutput("stream_payload", 64'(out_payload), 64'h100 + 64'(k));
        end
        idleIn();
        #1;
        checkOutput("stream_busy", 64'(busy_vec), 64'h1E);
        for (int k = 1; k <= 4; k++) writeBack(5'(k));
        checkOutput("stream_drained", 64'(out_valid), 64'd0);
        checkOutput("stream_wb_clear", 64'(busy_vec), 64'd0);

        // RAW stall then zero-bubble release on writeback
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 32'hA000_0001);
        tick();
        applyStimulus(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 32'hB000_0002);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("raw_stall_ready", 64'(in_ready), 64'd0);
            tick();
        end
        checkOutput("raw_stall_cnt", 64'(stall_cnt), 64'd3);
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        #1;
        checkOutput("raw_bypass_ready", 64'(in_ready), 64'd1);
        tick();
        wb_valid = 1'b0;
        idleIn();
        checkOutput("raw_fire_valid", 64'(out_valid), 64'd1);
        checkOutput("raw_fire_payload", 64'(out_payload), 64'hB000_0002);
        checkOutput("raw_fire_rs", 64'(out_rs), 64'd5);
        checkOutput("raw_busy", 64'(busy_vec), 64'h40);
        checkOutput("raw_stall_hold", 64'(stall_cnt), 64'd3);
        writeBack(5'd6);
        checkOutput("raw_clear", 64'(busy_vec), 64'd0);

        // WAW: same-cycle writeback and new producer of r7, set wins
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 32'hC000_0003);
        tick();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 32'hD000_0004);
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        #1;
        checkOutput("waw_bypass_ready", 64'(in_ready), 64'd1);
        tick();
        wb_valid = 1'b0;
        checkOutput("waw_set_wins", 64'(busy_vec), 64'h80);
        checkOutput("waw_payload", 64'(out_payload), 64'hD000_0004);
        #1;
        checkOutput("waw_stall_ready", 64'(in_ready), 64'd0);
        idleIn();
        writeBack(5'd7);
        checkOutput("waw_clear", 64'(busy_vec), 64'd0);
        checkOutput("waw_stall_cnt", 64'(stall_cnt), 64'd3);

        // Back-pressure: output held for 5 cycles, then reload without a bubble
        out_ready = 1'b0;
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 32'hE000_0005);
        tick();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 32'hF000_0006);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_payload", 64'(out_payload), 64'hE000_0005);
            checkOutput("bp_rd", 64'(out_rd), 64'd8);
            tick();
        end
        checkOutput("bp_stall_cnt", 64'(stall_cnt), 64'd8);
        checkOutput("bp_busy_hold", 64'(busy_vec), 64'h100);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        idleIn();
        checkOutput("bp_reload_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_reload_payload", 64'(out_payload), 64'hF000_0006);
        checkOutput("bp_busy", 64'(busy_vec), 64'h300);
        writeBack(5'd8);
        writeBack(5'd9);
        checkOutput("bp_clear", 64'(busy_vec), 64'd0);

        // Register 0 is never busy
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0007);
        #1;
        checkOutput("r0_ready1", 64'(in_ready), 64'd1);
        tick();
        checkOutput("r0_busy1", 64'(busy_vec), 64'd0);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 32'h0000_0008);
        #1;
        checkOutput("r0_ready2", 64'(in_ready), 64'd1);
        tick();
        idleIn();
        checkOutput("r0_busy2", 64'(busy_vec), 64'd0);
        checkOutput("r0_payload", 64'(out_payload), 64'h0000_0008);
        checkOutput("r0_stall", 64'(stall_cnt), 64'd8);

        // Flush with r1..r7 busy and output full, then reset
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b1, 5'd0, 5'd0, 5'(k), 1'b0, 1'b0, 1'b1, 32'h200 + 32'(k));
            tick();
        end
        idleIn();
        checkOutput("fl_pre_busy", 64'(busy_vec), 64'hFE);
        checkOutput("fl_pre_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        flush     = 1'b1;
        #1;
        checkOutput("fl_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        checkOutput("fl_busy", 64'(busy_vec), 64'd0);
        checkOutput("fl_out_valid", 64'(out_valid), 64'd0);
        checkOutput("fl_stall", 64'(stall_cnt), 64'd8);
        writeBack(5'd3);
        checkOutput("fl_late_wb", 64'(busy_vec), 64'd0);
        out_ready = 1'b1;
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 32'h300);
        tick();
        idleIn();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst2_stall", 64'(stall_cnt), 64'd0);
        checkOutput("rst2_valid", 64'(out_valid), 64'd0);
        checkOutput("rst2_busy", 64'(busy_vec), 64'd0);
        checkOutput("rst2_payload", 64'(out_payload), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
